// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the core port (c_*) and the debug/loader port (d_*)
// Ports: clk/resetn (async active-low); c_*/d_* requester ports (req held until ack, one-cycle ack,
// rdata valid with ack); m_* memory strobe/write/address/data out, m_rdata in (valid cycle after m_en);
// busy high whenever the FSM is not idle.
// Config: define MEM_ARB_DEBUG_PRIO_EN for fixed debug-over-core priority; default is round-robin.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, DONE} stateT;
  stateT state;
  logic gntD;
  logic gntWe;
  logic pickD;
`ifdef MEM_ARB_DEBUG_PRIO_EN
  assign pickD = d_req;
`else
  // lastGnt = 1 means debug was served last, so the core wins the next tie
  logic lastGnt;
  assign pickD = d_req & (~c_req | ~lastGnt);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) lastGnt <= 1'b1;
    else if (state == IDLE && (c_req || d_req)) lastGnt <= pickD;
`endif
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      gntD    <= 1'b0;
      gntWe   <= 1'b0;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      c_ack   <= 1'b0;
      d_ack   <= 1'b0;
      c_rdata <= '0;
      d_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (c_req || d_req) begin
          m_en    <= 1'b1;
          m_we    <= pickD ? d_we : c_we;
          m_addr  <= pickD ? d_addr : c_addr;
          m_wdata <= pickD ? d_wdata : c_wdata;
          gntD    <= pickD;
          gntWe   <= pickD ? d_we : c_we;
          state   <= ACCESS;
        end
        ACCESS: begin
          m_en  <= 1'b0;
          m_we  <= 1'b0;
          state <= RESP;
        end
        RESP: begin
          // writes still ack but leave the port's rdata untouched
          if (!gntWe && gntD) d_rdata <= m_rdata;
          if (!gntWe && !gntD) c_rdata <= m_rdata;
          c_ack <= ~gntD;
          d_ack <= gntD;
          state <= DONE;
        end
        default: begin
          c_ack <= 1'b0;
          d_ack <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port unified instruction/data memory of the multicycle RISC-V core between the core's memory interface and a debug/loader port (UART program loader). It sits between the datapath's memory address/data lines and the memory macro. It serialises accesses through a small FSM and returns read data with a one-cycle ack pulse per transaction.

## Interface
Parameters:
- ADDR_W, 32, byte address width passed to memory.
- DATA_W, 32, data word width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- c_req  in  1  core request; held high until c_ack.
- c_we  in  1  core write enable (1 = write, 0 = read).
- c_addr  in  ADDR_W  core address.
- c_wdata  in  DATA_W  core write data.
- c_rdata  out  DATA_W  core read data, valid when c_ack.
- c_ack  out  1  one-cycle core completion pulse.
- d_req, d_we, d_addr, d_wdata, d_rdata, d_ack  (same directions/widths)  debug port, same semantics as core port.
- m_en  out  1  memory access strobe.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data, valid the cycle after m_en.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE → ACCESS → RESP → DONE → IDLE. No other transitions except reset.
- IDLE: when any req is high, select the winner. Register m_en=1, m_we, m_addr and m_wdata from the winner. Latch grant id and go to ACCESS. With no req, stay in IDLE with m_en=0.
- ACCESS: m_en high for exactly this one cycle; memory samples at the end of the cycle. Go to RESP, clearing m_en/m_we.
- RESP: m_rdata is valid. On a read, register it into the granted port's rdata. Pulse the granted port's ack in the next cycle. Go to DONE.
- DONE: granted ack = 1 for this cycle only. All reqs are ignored in DONE. Go to IDLE.
- Writes: same timing. The ack is still issued. The port's rdata is left unchanged.
- Requester rules: req, we, addr and wdata stay stable from req assertion until the ack cycle. Req drops or carries a new request from the cycle after ack. Input changes while not in IDLE are ignored.
- Arbitration (default): round-robin using a 1-bit last_gnt.
  - When both reqs are high, the port not last granted wins.
  - A single requester always wins.
  - last_gnt updates on every grant.
- The non-granted port sees no ack and waits.
- rdata of each port holds its last read value until overwritten.

## Timing
- Request in cycle 0 (IDLE) → m_en in cycle 1 → ack in cycle 3. Minimum occupancy is 4 cycles per transaction. The next grant is decided in cycle 4.
- Reset (asynchronous, immediate):
  - State: IDLE.
  - Outputs: m_en=0, m_we=0, m_addr=0, m_wdata=0, c_ack=d_ack=0, c_rdata=d_rdata=0, busy=0.
  - last_gnt=1, so the core wins the first tie.
- Reset mid-transaction: the in-flight access is abandoned and no ack is issued. A request still held after release is served from IDLE as new.
- Simultaneous requests in IDLE are resolved in the same cycle; there is no lost request.
- The core stalls naturally: the controller waits for c_ack.

## Configuration
- MEM_ARB_DEBUG_PRIO_EN:
  - Defined: fixed priority. d_req always wins over c_req in IDLE and last_gnt is ignored, so the loader can halt the core's memory traffic.
  - Undefined: round-robin as above.

## Test plan
- Core read alone: mem[0x10]=0xDEADBEEF, c_req/c_addr=0x10 in cycle 0 → m_en=1, m_addr=0x10 in cycle 1; c_ack=1, c_rdata=0xDEADBEEF in cycle 3; d_ack stays 0.
- Debug write then core read: d write 0x20←0x12345678 with d_ack in cycle 3, m_we=1 in cycle 1 → core read of 0x20 returns 0x12345678; d_rdata unchanged.
- Simultaneous reqs after reset: core granted first (m_addr=c_addr in cycle 1, c_ack cycle 3); debug m_en in cycle 5, d_ack in cycle 7. With MEM_ARB_DEBUG_PRIO_EN the order is reversed.
- Both reqs held continuously for 4 transactions → grant order C,D,C,D (round-robin); with macro → D,D,D,D.
- resetn low during ACCESS → m_en=0 and busy=0 immediately, no ack. After release, the held c_req completes with c_ack 3 cycles after the first IDLE cycle.
- c_addr changed from 0x10 to 0x14 during ACCESS → memory sees 0x10 only; returned data is mem[0x10].
